// File: rtl/rv_dmem_ctrl_if.sv
// Data-bus interface between the memory-access controller and the data memory.
// The controller is the master: it issues requests and receives read responses.
interface rv_dmem_ctrl_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_wr;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_be,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_be,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/rv_dmem_ctrl.sv
// Data-memory access controller: one load/store per transaction from the core,
// byte-lane stores, sign/zero-extended loads, misalignment and timeout reporting.
module rv_dmem_ctrl #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RD_DATA    = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_req_valid,
    input  logic               core_req_wr,
    input  logic [31:0]        core_req_addr,
    input  logic [31:0]        core_req_wr_data,
    input  logic [1:0]         core_req_size,
    input  logic               core_req_unsigned,
    output logic               core_ready,
    output logic [31:0]        core_rd_data,
    output logic               core_misaligned,
    output logic               err_timeout,
    rv_dmem_ctrl_if.master     bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACC = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Counter only needs to reach TIMEOUT_CYCLES; with the timeout disabled it may wrap freely.
    localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic          valid_q, valid_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          mis_s;

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] r;
        case (sz)
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Half on an odd byte or word off a word boundary cannot be issued to the bus.
    assign mis_s = ((core_req_size == 2'b01) && core_req_addr[0]) ||
                   (core_req_size[1] && (core_req_addr[1:0] != 2'b00));

    // Next-state logic: request latch, bus handshake, response capture and timeout.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req_valid && !mis_s) begin
                    wr_d    = core_req_wr;
                    addr_d  = core_req_addr;
                    size_d  = core_req_size;
                    uns_d   = core_req_unsigned;
                    wdata_d = core_req_wr ? lane_wdata(core_req_size, core_req_wr_data) : 32'h0000_0000;
                    be_d    = core_req_wr ? lane_be(core_req_size, core_req_addr[1:0]) : 4'b0000;
                    valid_d = 1'b1;
                    state_d = ST_WAIT_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACC: begin
                if (bus.bus_req_ready) begin
                    valid_d = 1'b0;
                    if (wr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_WAIT_RSP;
                    end
                end else begin
                    state_d = ST_WAIT_ACC;
                end
            end
            ST_WAIT_RSP: begin
                // A response in the limit cycle takes priority over the timeout.
                if (bus.bus_rsp_valid) begin
                    rdata_d = load_ext(bus.bus_rsp_rdata, addr_q[1:0], size_q, uns_q);
                    state_d = ST_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIM)) begin
                    rdata_d = ERR_RD_DATA;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            cnt_q   <= {CW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Core-side handshake: combinational only in IDLE, otherwise from the state register.
    always_comb begin
        core_ready      = 1'b0;
        core_rd_data    = 32'h0000_0000;
        core_misaligned = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_ready      = !core_req_valid || mis_s;
                core_misaligned = core_req_valid && mis_s;
            end
            ST_DONE: begin
                core_ready   = 1'b1;
                core_rd_data = rdata_q;
            end
            default: begin
                core_ready = 1'b0;
            end
        endcase
    end

    assign bus.bus_req_valid = valid_q;
    assign bus.bus_req_wr    = wr_q;
    assign bus.bus_req_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_req_wdata = wdata_q;
    assign bus.bus_req_be    = be_q;
    assign err_timeout       = err_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Directed scoreboard bench for rv_dmem_ctrl with a small data-bus responder.
module tb_rv_dmem_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid;
    logic        core_req_wr;
    logic [31:0] core_req_addr;
    logic [31:0] core_req_wr_data;
    logic [1:0]  core_req_size;
    logic        core_req_unsigned;
    logic        core_ready;
    logic [31:0] core_rd_data;
    logic        core_misaligned;
    logic        err_timeout;

    rv_dmem_ctrl_if bus_if ();

    rv_dmem_ctrl #(.TIMEOUT_CYCLES(T), .ERR_RD_DATA(32'hDEAD_BEEF)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .core_req_valid    (core_req_valid),
        .core_req_wr       (core_req_wr),
        .core_req_addr     (core_req_addr),
        .core_req_wr_data  (core_req_wr_data),
        .core_req_size     (core_req_size),
        .core_req_unsigned (core_req_unsigned),
        .core_ready        (core_ready),
        .core_rd_data      (core_rd_data),
        .core_misaligned   (core_misaligned),
        .err_timeout       (err_timeout),
        .bus               (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core transaction with a bus responder: ready_hold = cycles bus_req_ready stays low
    // after bus_req_valid rises, rsp_lat = cycles from acceptance to response (-1 = never).
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input int ready_hold, input int rsp_lat, input logic [31:0] rsp_word,
                       input logic [31:0] exp_data, input logic exp_mis,
                       input logic [31:0] exp_baddr, input logic [31:0] exp_bwdata,
                       input logic [3:0] exp_be);
        exp_t e;
        exp_t got;
        int   first_v = -1;
        int   acc     = -1;
        int   done    = -1;
        int   exp_done;
        e.chk_data = !wr || exp_mis;
        e.data     = exp_data;
        e.mis      = exp_mis;
        sb_q.push_back(e);
        if (exp_mis)      exp_done = 0;
        else if (wr)      exp_done = 1 + ready_hold + 1;
        else if (rsp_lat < 0) exp_done = 1 + ready_hold + T + 2;
        else              exp_done = 1 + ready_hold + 1 + rsp_lat;
        for (int c = 0; c < 200 && done < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                core_req_valid    = 1'b1;
                core_req_wr       = wr;
                core_req_addr     = addr;
                core_req_wr_data  = wdata;
                core_req_size     = size;
                core_req_unsigned = uns;
            end
            bus_if.bus_req_ready = 1'b0;
            bus_if.bus_rsp_valid = 1'b0;
            bus_if.bus_rsp_rdata = $urandom;
            #1;
            if (bus_if.bus_req_valid && acc < 0) begin
                if (first_v < 0) first_v = c;
                chk({tag, "_baddr"}, bus_if.bus_req_addr, exp_baddr);
                chk({tag, "_bwdata"}, bus_if.bus_req_wdata, exp_bwdata);
                chk({tag, "_be"}, {28'h0, bus_if.bus_req_be}, {28'h0, exp_be});
                chk({tag, "_bwr"}, {31'h0, bus_if.bus_req_wr}, {31'h0, wr});
                if (c - first_v >= ready_hold) begin
                    bus_if.bus_req_ready = 1'b1;
                    acc = c;
                end
            end
            if (acc >= 0 && !wr && rsp_lat >= 0 && c == acc + rsp_lat) begin
                bus_if.bus_rsp_valid = 1'b1;
                bus_if.bus_rsp_rdata = rsp_word;
            end
            if (core_ready) begin
                done = c;
                got  = sb_q.pop_front();
                chk({tag, "_mis"}, {31'h0, core_misaligned}, {31'h0, got.mis});
                if (got.chk_data) chk({tag, "_rdata"}, core_rd_data, got.data);
            end
        end
        chk({tag, "_done_cycle"}, 32'(done), 32'(exp_done));
        chk({tag, "_first_valid"}, 32'(first_v), exp_mis ? 32'hFFFF_FFFF : 32'd1);
        @(negedge clk);
        core_req_valid       = 1'b0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        core_req_valid       = 1'b0;
        core_req_wr          = 1'b0;
        core_req_addr        = 32'h0;
        core_req_wr_data     = 32'h0;
        core_req_size        = 2'b00;
        core_req_unsigned    = 1'b0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_core_ready", {31'h0, core_ready}, 32'd1);
        chk("rst_bus_valid", {31'h0, bus_if.bus_req_valid}, 32'd0);
        chk("rst_be", {28'h0, bus_if.bus_req_be}, 32'd0);
        chk("rst_baddr", bus_if.bus_req_addr, 32'd0);
        chk("rst_err", {31'h0, err_timeout}, 32'd0);

        // tag, wr, addr, wdata, size, uns, hold, lat, rsp, exp_data, mis, baddr, bwdata, be
        txn("sb",   1'b1, 32'h1003, 32'h0000_00A5, 2'b00, 1'b0, 0, -1, 32'h0, 32'h0, 1'b0, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
        txn("sb0",  1'b1, 32'h1000, 32'h1234_5677, 2'b00, 1'b0, 0, -1, 32'h0, 32'h0, 1'b0, 32'h1000, 32'h7777_7777, 4'b0001);
        txn("sh",   1'b1, 32'h6002, 32'h1234_BEEF, 2'b01, 1'b0, 1, -1, 32'h0, 32'h0, 1'b0, 32'h6000, 32'hBEEF_BEEF, 4'b1100);
        txn("sw",   1'b1, 32'h6004, 32'hCAFE_F00D, 2'b10, 1'b0, 0, -1, 32'h0, 32'h0, 1'b0, 32'h6004, 32'hCAFE_F00D, 4'b1111);
        txn("lh",   1'b0, 32'h2002, 32'h0, 2'b01, 1'b0, 0, 1, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 32'h2000, 32'h0, 4'b0000);
        txn("lhu",  1'b0, 32'h2002, 32'h0, 2'b01, 1'b1, 0, 1, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 32'h2000, 32'h0, 4'b0000);
        txn("lhlo", 1'b0, 32'h8000, 32'h0, 2'b01, 1'b0, 0, 2, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0, 32'h8000, 32'h0, 4'b0000);
        txn("lb",   1'b0, 32'h5001, 32'h0, 2'b00, 1'b0, 0, 1, 32'h0000_8000, 32'hFFFF_FF80, 1'b0, 32'h5000, 32'h0, 4'b0000);
        txn("lbu",  1'b0, 32'h5003, 32'h0, 2'b00, 1'b1, 0, 1, 32'hF100_0000, 32'h0000_00F1, 1'b0, 32'h5000, 32'h0, 4'b0000);
        txn("lw3",  1'b0, 32'h9000, 32'h0, 2'b11, 1'b0, 0, 1, 32'h8765_4321, 32'h8765_4321, 1'b0, 32'h9000, 32'h0, 4'b0000);
        txn("lwst", 1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 5, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h4000, 32'h0, 4'b0000);
        txn("lwmis", 1'b0, 32'h3001, 32'h0, 2'b10, 1'b0, 0, -1, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0000);
        txn("shmis", 1'b1, 32'h6001, 32'hFFFF, 2'b01, 1'b0, 0, -1, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0000);
        // Response lands in the same cycle the counter hits its limit: data wins, no error.
        txn("lwlim", 1'b0, 32'hA000, 32'h0, 2'b10, 1'b0, 0, T + 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 32'hA000, 32'h0, 4'b0000);
        chk("lim_no_err", {31'h0, err_timeout}, 32'd0);
        txn("lwto", 1'b0, 32'hB000, 32'h0, 2'b10, 1'b0, 0, -1, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hB000, 32'h0, 4'b0000);
        chk("to_err", {31'h0, err_timeout}, 32'd1);
        txn("lwpost", 1'b0, 32'hB004, 32'h0, 2'b10, 1'b0, 0, 3, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 32'hB004, 32'h0, 4'b0000);
        chk("to_sticky", {31'h0, err_timeout}, 32'd1);

        // Reset while a load waits for its response.
        @(negedge clk);
        core_req_valid    = 1'b1;
        core_req_wr       = 1'b0;
        core_req_addr     = 32'h7000;
        core_req_size     = 2'b10;
        core_req_unsigned = 1'b0;
        @(negedge clk);
        bus_if.bus_req_ready = 1'b1;
        #1;
        chk("rr_acc_valid", {31'h0, bus_if.bus_req_valid}, 32'd1);
        @(negedge clk);
        bus_if.bus_req_ready = 1'b0;
        #1;
        chk("rr_wait_ready", {31'h0, core_ready}, 32'd0);
        rst            = 1'b1;
        core_req_valid = 1'b0;
        #1;
        chk("rr_bus_valid", {31'h0, bus_if.bus_req_valid}, 32'd0);
        chk("rr_idle", {31'h0, core_ready}, 32'd1);
        chk("rr_err_clr", {31'h0, err_timeout}, 32'd0);
        @(negedge clk);
        rst                  = 1'b0;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rsp_rdata = 32'hFFFF_0000;
        #1;
        chk("rr_late_idle", {31'h0, core_ready}, 32'd1);
        @(negedge clk);
        bus_if.bus_rsp_valid = 1'b0;
        #1;
        chk("rr_late_ready", {31'h0, core_ready}, 32'd1);
        chk("rr_late_valid", {31'h0, bus_if.bus_req_valid}, 32'd0);
        txn("lwrr", 1'b0, 32'h7000, 32'h0, 2'b10, 1'b0, 0, 1, 32'h0F0F_1234, 32'h0F0F_1234, 1'b0, 32'h7000, 32'h0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
